count_bcd_converter: RTL and testbench
======================================

# count_bcd_converter

Sequential binary-to-BCD converter placed directly downstream of the 8-bit free-running counter (`counter_structural`). It samples the counter's `q` value through a valid/ready input handshake and converts it with the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It then presents packed BCD digits through a valid/ready output handshake to the display stage.

## Interface
- `WIDTH`, default 8: binary input width.
- `DIGITS`, default 3: number of BCD output digits.
  - Must satisfy 10^DIGITS > 2^WIDTH − 1.
  - The bench checks this at elaboration.
- `clk`, input, 1: single clock; all logic uses the rising edge.
- `rst_n`, input, 1: synchronous, active-low reset, sampled on the `clk` rising edge.
- `in_valid`, input, 1: `in_data` is valid.
- `in_ready`, output, 1: block can accept a new value.
- `in_data`, input, WIDTH: binary value, normally the counter's `q`.
- `out_valid`, output, 1: `out_bcd` holds a completed conversion.
- `out_ready`, input, 1: downstream accepts `out_bcd`.
- `out_bcd`, output, 4*DIGITS: packed BCD.
  - Bits [3:0] are the ones digit; the most significant nibble is the highest digit.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE**
  - `in_ready` = 1.
  - On an edge with `in_valid` && `in_ready`: capture `in_data` into the binary shift register, clear the BCD register, clear the bit counter, go to SHIFT.
- **SHIFT**
  - `in_ready` = 0.
  - Each edge, first adjust: every BCD nibble ≥ 5 gets +3 (4-bit, no carry between nibbles).
  - Then shift {BCD, bin} left by 1 and increment the bit counter.
  - After WIDTH iterations go to DONE and load `out_bcd`.
- **DONE**
  - `out_valid` = 1. `out_bcd` is stable.
  - On an edge with `out_valid` && `out_ready`: go to IDLE, deassert `out_valid`.
- `in_ready` = (state == IDLE) && `rst_n`.
- `in_data` changes while the block is not in IDLE are ignored. The captured value is never re-sampled.
- The bit counter width is clog2(WIDTH+1). It never wraps, because the terminal count forces the exit from SHIFT.
- Results are exact for all inputs 0 to 2^WIDTH − 1. No nibble ever exceeds 9 in `out_bcd`.

## Timing
- **Reset** (`rst_n` low at an edge):
  - State is IDLE, `out_valid` = 0, `out_bcd` = 0, internal registers = 0.
  - `in_ready` = 0 while `rst_n` is low and 1 from the first edge after release.
- **Latency:** value accepted at edge k → `out_valid` high after edge k+WIDTH (8 cycles at the default width).
- **Throughput** with `out_ready` tied high:
  - Output handshake at edge k+WIDTH+1, back in IDLE, next accept at edge k+WIDTH+2.
  - One sample per WIDTH+2 cycles (10 at the default). Upstream counter values in between are dropped by design.
- **Backpressure:** while `out_valid` && !`out_ready`, `out_bcd` and `out_valid` hold indefinitely and `in_ready` stays 0.
- **Reset mid-SHIFT or mid-DONE:** the conversion is discarded. `out_valid` must not pulse, and `out_bcd` returns to 0.
- **Simultaneous events:** `rst_n` low overrides any handshake on the same edge.
- No combinational path from `in_valid` to `out_*`, or from `out_ready` to `in_ready` within the same cycle, except through the state register.

## Structure
- Shared package `count_pkg` holds:
  - `COUNT_WIDTH` = 8, `BCD_DIGITS` = 3, `NIBBLE_W` = 4.
  - The FSM state encoding: IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2.
- One sub-module, `bcd_digit_adj`: 4-bit combinational "if ≥ 5 add 3".
  - Instantiated DIGITS times in a generate loop.
- Top level contains the FSM, the bit counter, the {BCD, bin} shift register and the output register.

## Test plan
- Reset then `in_data` = 0, `in_valid` pulse → `out_bcd` = 12'h000, `out_valid` rises exactly 8 cycles after acceptance.
- `in_data` = 255 → `out_bcd` = 12'h255; `in_data` = 99 → 12'h099; `in_data` = 100 → 12'h100.
- Accepted 173 with `out_ready` held low 5 extra cycles → `out_bcd` = 12'h173 stable throughout, `in_ready` = 0, a single handshake when `out_ready` rises.
- `rst_n` low for one edge during the 4th SHIFT cycle → `out_valid` never asserts, `out_bcd` = 0, `in_ready` = 1 on the following edge.
- `in_data` toggled while in SHIFT → result equals the value captured at acceptance.
- Driven by `counter_structural` (`q` → `in_data`, `in_valid` = 1, `out_ready` = 1) for 1000 ns → every result decodes to its sampled count, samples are spaced 10 cycles apart, and the 255→0 wrap converts correctly.

Source files
------------

// File: rtl/count_pkg.sv
// Shared constants, state encoding and the double-dabble nibble correction
// used by the counter-to-BCD conversion path.
package count_pkg;

  localparam int COUNT_WIDTH = 8;
  localparam int BCD_DIGITS  = 3;
  localparam int NIBBLE_W    = 4;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // A nibble of 5 or more would overflow past 9 once doubled, so it is
  // pre-biased by 3; the carry then lands in the next nibble after the shift.
  function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
    logic [3:0] res;
    if (nib >= 4'd5) begin
      res = nib + 4'd3;
    end else begin
      res = nib;
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit of the shift-and-add-3 datapath: combinational ">= 5 add 3".
module bcd_digit_adj
  import count_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // Pure per-digit correction, no carry into neighbouring digits
  always_comb begin
    digit_o = dabble_adj(digit_i);
  end

endmodule

// File: rtl/count_bcd_converter.sv
// Sequential binary-to-BCD converter fed by the free-running counter:
// valid/ready capture, one double-dabble step per clock, valid/ready result.
module count_bcd_converter
  import count_pkg::*;
#(
  parameter int WIDTH  = COUNT_WIDTH,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NIBBLE_W*DIGITS-1:0]   out_bcd
);

  localparam int BCD_W = NIBBLE_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [BCD_W-1:0]   out_bcd_q, out_bcd_d;

  logic [BCD_W-1:0]   bcd_adj_s;
  logic [BCD_W-1:0]   bcd_shift_s;
  logic [WIDTH-1:0]   bin_shift_s;
  logic               in_ready_s;
  logic               in_hs_s;
  logic               out_hs_s;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (bcd_q[g*NIBBLE_W +: NIBBLE_W]),
      .digit_o (bcd_adj_s[g*NIBBLE_W +: NIBBLE_W])
    );
  end

  // Handshake qualifiers; in_ready also drops while reset is asserted
  always_comb begin
    in_ready_s = (state_q == ST_IDLE) && rst_n;
    in_hs_s    = in_valid && in_ready_s;
    out_hs_s   = out_valid_q && out_ready;
  end

  // {BCD, bin} shifted left by one after the per-digit correction
  always_comb begin
    bcd_shift_s = {bcd_adj_s[BCD_W-2:0], bin_q[WIDTH-1]};
    bin_shift_s = {bin_q[WIDTH-2:0], 1'b0};
  end

  // FSM and datapath next-state
  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_bcd_d   = out_bcd_q;
    case (state_q)
      ST_IDLE: begin
        if (in_hs_s) begin
          state_d = ST_SHIFT;
          bin_d   = in_data;
          bcd_d   = {BCD_W{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        bin_d = bin_shift_s;
        bcd_d = bcd_shift_s;
        cnt_d = cnt_q + CNT_ONE;
        // Terminal count forces the exit, so the counter never wraps
        if (cnt_q == LAST_CNT) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          out_bcd_d   = bcd_shift_s;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (out_hs_s) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset discards any conversion in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bin_q       <= {WIDTH{1'b0}};
      bcd_q       <= {BCD_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      out_valid_q <= 1'b0;
      out_bcd_q   <= {BCD_W{1'b0}};
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_bcd_q   <= out_bcd_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign out_bcd   = out_bcd_q;

endmodule

// File: tb/tb_count_bcd_converter.sv
// Self-checking bench for count_bcd_converter: table vectors, scoreboard,
// backpressure, reset mid-conversion and a free-running counter stream.
module tb_count_bcd_converter;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;
  localparam int BCD_W  = 4 * DIGITS;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [BCD_W-1:0] out_bcd;

  count_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd)
  );

  typedef struct {
    logic [WIDTH-1:0] din;
    logic [BCD_W-1:0] exp;
  } vec_t;

  typedef struct {
    logic [BCD_W-1:0] exp;
    int               acc_edge;
  } sb_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   pops = 0;
  int   ov_cycles = 0;
  sb_t  sb_q[$];
  logic [BCD_W-1:0] last_out = '0;
  bit   stream_mode = 1'b0;
  bit   have_prev = 1'b0;
  bit   saw_wrap = 1'b0;
  int   prev_acc_edge = 0;
  int   stream_accepts = 0;
  logic [WIDTH-1:0] prev_acc_val = '0;
  vec_t vecs[9];

  initial begin
    if (10**DIGITS <= 2**WIDTH - 1) begin
      $display("FAIL digits_param: DIGITS=%0d too small for WIDTH=%0d", DIGITS, WIDTH);
      $fatal(1);
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [BCD_W-1:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard: looks just after each falling edge at what the next
  // rising edge will see.
  initial begin
    sb_t e;
    bit  prev_ov;
    bit  nib_ok;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n !== 1'b1) begin
        sb_q.delete();
      end else begin
        if (in_valid && in_ready) begin
          sb_q.push_back('{exp: to_bcd(int'(in_data)), acc_edge: cyc + 1});
          if (stream_mode) begin
            stream_accepts++;
            if (have_prev) begin
              chk("stream_spacing", cyc + 1 - prev_acc_edge, 10);
              if (in_data < prev_acc_val) saw_wrap = 1'b1;
            end
            have_prev     = 1'b1;
            prev_acc_edge = cyc + 1;
            prev_acc_val  = in_data;
          end
        end
        if (out_valid === 1'b1) begin
          chk("busy_in_ready", in_ready, 0);
          if (sb_q.size() == 0) begin
            chk("unexpected_out_valid", out_valid, 0);
          end else begin
            if (!prev_ov) chk("latency", cyc - sb_q[0].acc_edge, WIDTH);
            if (out_ready) begin
              e = sb_q.pop_front();
              pops++;
              last_out = out_bcd;
              chk("scoreboard_bcd", out_bcd, e.exp);
              nib_ok = 1'b1;
              for (int i = 0; i < DIGITS; i++)
                if (out_bcd[4*i +: 4] > 4'd9) nib_ok = 1'b0;
              chk("nibble_le9", nib_ok, 1);
            end else begin
              chk("hold_bcd", out_bcd, e.exp === 'x ? sb_q[0].exp : sb_q[0].exp);
            end
          end
        end
      end
      if (out_valid === 1'b1) ov_cycles++;
      prev_ov = (out_valid === 1'b1);
    end
  end

  task automatic send(input logic [WIDTH-1:0] d);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = ~d;
  endtask

  task automatic wait_pop(input int p0);
    int n;
    n = 0;
    while (pops <= p0 && n < 40) begin
      @(negedge clk);
      in_data = WIDTH'($urandom);
      n++;
    end
    if (pops <= p0) chk("output_timeout", pops, p0 + 1);
  endtask

  initial begin
    int p0;
    int ov0;
    int n;
    logic [WIDTH-1:0] ctr;

    vecs[0] = '{din: 8'd0,   exp: 12'h000};
    vecs[1] = '{din: 8'd255, exp: 12'h255};
    vecs[2] = '{din: 8'd99,  exp: 12'h099};
    vecs[3] = '{din: 8'd100, exp: 12'h100};
    vecs[4] = '{din: 8'd1,   exp: 12'h001};
    vecs[5] = '{din: 8'd9,   exp: 12'h009};
    vecs[6] = '{din: 8'd10,  exp: 12'h010};
    vecs[7] = '{din: 8'd199, exp: 12'h199};
    vecs[8] = '{din: 8'd58,  exp: 12'h058};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_data   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_bcd", out_bcd, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_in_ready", in_ready, 1);
    chk("release_out_valid", out_valid, 0);

    // Table vectors; in_data is scrambled every cycle while converting
    for (int i = 0; i < 9; i++) begin
      p0 = pops;
      send(vecs[i].din);
      wait_pop(p0);
      chk("table_bcd", last_out, vecs[i].exp);
    end

    // Backpressure with 173
    out_ready = 1'b0;
    send(8'd173);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_bcd_stable", out_bcd, 12'h173);
      chk("bp_valid_hold", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      in_valid = 1'b1;
      in_data  = 8'd5;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    p0        = pops;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("bp_single_handshake", pops - p0, 1);
    chk("bp_last_out", last_out, 12'h173);
    chk("bp_valid_dropped", out_valid, 0);
    chk("bp_sb_empty", sb_q.size(), 0);

    // Reset during the 4th SHIFT cycle
    send(8'd77);
    repeat (2) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_bcd", out_bcd, 0);
    chk("midrst_in_ready_low", in_ready, 0);
    rst_n = 1'b1;
    ov0   = ov_cycles;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 1);
    repeat (12) @(negedge clk);
    chk("midrst_no_valid", ov_cycles - ov0, 0);
    chk("midrst_sb_empty", sb_q.size(), 0);

    // Free-running counter stream for 100 cycles, crossing the 255->0 wrap
    out_ready   = 1'b1;
    have_prev   = 1'b0;
    stream_mode = 1'b1;
    ctr = 8'd200;
    repeat (100) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = ctr;
      ctr++;
    end
    @(negedge clk);
    in_valid    = 1'b0;
    stream_mode = 1'b0;
    n = 0;
    while ((sb_q.size() != 0 || out_valid === 1'b1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("stream_drained", sb_q.size(), 0);
    chk("stream_accepts", stream_accepts, 10);
    chk("stream_wrap_seen", saw_wrap, 1);

    repeat (3) @(negedge clk);
    chk("final_out_valid", out_valid, 0);
    chk("final_in_ready", in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
